// File: rtl/taintcell_fifo.sv
// taintcell_fifo: shadow taint-tracking cell for a synchronous first-word-fall-through FIFO.
// Mirrors the host FIFO pointers and keeps, per entry, a taint word plus a shadow copy of the
// data, so that control-flow taint on PUSH/POP can be turned into data taint.
module taintcell_fifo #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned DEPTH     = 8,
  parameter string       MODE      = "precise",
  parameter int unsigned SUM_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                 CLK,
  input  logic                 ARST_N,
  input  logic                 PUSH,
  input  logic                 POP,
  input  logic [WIDTH-1:0]     DIN,
  input  logic                 PUSH_taint,
  input  logic                 POP_taint,
  input  logic [WIDTH-1:0]     DIN_taint,
  output logic [WIDTH-1:0]     DOUT_taint,
  output logic                 FULL_taint,
  output logic                 EMPTY_taint,
  output logic                 ctrl_taint,
  output logic [SUM_WIDTH-1:0] taint_sum
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam bit Conservative = (MODE == "conservative");

  // Elaboration-time parameter sanity checks.
  if (!((MODE == "precise") || (MODE == "conservative"))) begin : gen_bad_mode
    $error("taintcell_fifo: unknown MODE '%s'", MODE);
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gen_bad_depth
    $error("taintcell_fifo: DEPTH %0d is not a power of two >= 2", DEPTH);
  end

  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]     mem_taint_q [DEPTH];
  logic [WIDTH-1:0]     shadow_q    [DEPTH];
  logic                 ctrl_q;
  logic [SUM_WIDTH-1:0] sum_q, sum_d;

  logic                 full, empty;
  logic                 push_ok, pop_ok;
  logic [WIDTH-1:0]     din_san;
  logic [WIDTH-1:0]     t_ctl;
  logic [WIDTH-1:0]     wr_taint;
  logic                 ctrl_set, ctrl_clr;
  logic [PtrW-1:0]      rd_ptr_nxt;

  // Host FIFO flags and accept rules, replicated exactly.
  always_comb begin
    full    = (count_q == CntW'(DEPTH));
    empty   = (count_q == '0);
    push_ok = PUSH & (~full | POP);
    pop_ok  = POP & ~empty;
    count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
  end

  // Unknown write data must not poison the shadow copy or the XOR taint term.
  always_comb begin
    din_san = $isunknown(DIN) ? '0 : DIN;
  end

  // Taint contributed by a tainted PUSH: every bit that could differ if the push had not
  // happened (precise), or every bit (conservative).
  always_comb begin
    t_ctl = '0;
    if (PUSH_taint) begin
      if (Conservative) begin
        t_ctl = '1;
      end else begin
        t_ctl = din_san ^ shadow_q[wr_ptr_q];
      end
    end
    wr_taint = DIN_taint | t_ctl;
  end

  // Pointer taint: any tainted PUSH taints the accept/drop decision; a tainted POP only
  // matters when it can actually move the read pointer. Set wins over clear.
  always_comb begin
    ctrl_set = PUSH_taint | (POP_taint & ~empty);
    ctrl_clr = (count_d == '0) & ~PUSH_taint & ~POP_taint & ~(|DIN_taint);
  end

  // Pointer and occupancy state.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
    end
  end

  // Entry storage: taint word and shadow data written together on an accepted push.
  // Popped entries are left stale and only overwritten by later pushes.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_taint_q[i] <= '0;
        shadow_q[i]    <= '0;
      end
    end else if (push_ok) begin
      mem_taint_q[wr_ptr_q] <= wr_taint;
      shadow_q[wr_ptr_q]    <= din_san;
    end
  end

  // Sticky control-taint flag.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      ctrl_q <= 1'b0;
    end else if (ctrl_set) begin
      ctrl_q <= 1'b1;
    end else if (ctrl_clr) begin
      ctrl_q <= 1'b0;
    end
  end

  // Count of valid entries (rd_ptr onward, wrapped) holding any taint.
  always_comb begin
    sum_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CntW'(i) < count_q) && (|mem_taint_q[rd_ptr_q + PtrW'(i)])) begin
        sum_d = sum_d + SUM_WIDTH'(1);
      end
    end
  end

  // Registered tainted-entry count, one cycle behind the storage it summarises.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  // Head-data taint, combinational from rd_ptr to match the FWFT host read path. Under
  // pointer taint the head could be this slot or the next one, so precise mode adds the
  // bits in which those two shadow words differ.
  always_comb begin
    rd_ptr_nxt = rd_ptr_q + PtrW'(1);
    if (!ctrl_q) begin
      DOUT_taint = empty ? '0 : mem_taint_q[rd_ptr_q];
    end else if (Conservative) begin
      DOUT_taint = '1;
    end else begin
      DOUT_taint = mem_taint_q[rd_ptr_q] | (shadow_q[rd_ptr_q] ^ shadow_q[rd_ptr_nxt]);
    end
  end

  // Flag taints follow the pointer taint directly.
  always_comb begin
    FULL_taint  = ctrl_q;
    EMPTY_taint = ctrl_q;
    ctrl_taint  = ctrl_q;
    taint_sum   = sum_q;
  end

endmodule

// File: tb/tb_taintcell_fifo.sv
// tb_taintcell_fifo: directed and random stimulus against a slot-array reference model,
// driving a precise and a conservative instance in parallel.
module tb_taintcell_fifo;

  localparam int DEPTH = 8;
  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        arst_n;
  logic        push, pop, push_t, pop_t;
  logic [63:0] din, din_t;
  logic [63:0] dout_p, dout_c;
  logic        full_p, full_c, empty_p, empty_c, ctrl_p, ctrl_c;
  logic [3:0]  sum_p, sum_c;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: physical slots, head index and occupancy.
  logic [63:0] m_sh [DEPTH];
  logic [63:0] m_tp [DEPTH];
  logic [63:0] m_tc [DEPTH];
  int          m_rd, m_cnt, m_sum_p, m_sum_c;
  bit          m_ctrl;

  taintcell_fifo #(.WIDTH(64), .DEPTH(DEPTH), .MODE("precise")) dut_p (
    .CLK(clk), .ARST_N(arst_n), .PUSH(push), .POP(pop), .DIN(din),
    .PUSH_taint(push_t), .POP_taint(pop_t), .DIN_taint(din_t),
    .DOUT_taint(dout_p), .FULL_taint(full_p), .EMPTY_taint(empty_p),
    .ctrl_taint(ctrl_p), .taint_sum(sum_p)
  );

  taintcell_fifo #(.WIDTH(64), .DEPTH(DEPTH), .MODE("conservative")) dut_c (
    .CLK(clk), .ARST_N(arst_n), .PUSH(push), .POP(pop), .DIN(din),
    .PUSH_taint(push_t), .POP_taint(pop_t), .DIN_taint(din_t),
    .DOUT_taint(dout_c), .FULL_taint(full_c), .EMPTY_taint(empty_c),
    .ctrl_taint(ctrl_c), .taint_sum(sum_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_sh[i] = '0;
      m_tp[i] = '0;
      m_tc[i] = '0;
    end
    m_rd = 0; m_cnt = 0; m_ctrl = 0; m_sum_p = 0; m_sum_c = 0;
  endtask

  function automatic int count_tainted(input bit cons);
    int n;
    n = 0;
    for (int i = 0; i < m_cnt; i++) begin
      int s;
      s = (m_rd + i) % DEPTH;
      if ((cons ? m_tc[s] : m_tp[s]) != 64'h0) n++;
    end
    return n;
  endfunction

  function automatic logic [63:0] exp_dout(input bit cons);
    if (!m_ctrl) return (m_cnt == 0) ? 64'h0 : (cons ? m_tc[m_rd] : m_tp[m_rd]);
    if (cons) return ALL1;
    return m_tp[m_rd] | (m_sh[m_rd] ^ m_sh[(m_rd + 1) % DEPTH]);
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    bit          full, empty, push_ok, pop_ok;
    int          w, cnt_n;
    logic [63:0] ds;
    ds      = $isunknown(din) ? 64'h0 : din;
    full    = (m_cnt == DEPTH);
    empty   = (m_cnt == 0);
    push_ok = push && (!full || pop);
    pop_ok  = pop && !empty;
    m_sum_p = count_tainted(1'b0);
    m_sum_c = count_tainted(1'b1);
    if (push_ok) begin
      w       = (m_rd + m_cnt) % DEPTH;
      m_tp[w] = din_t | (push_t ? (ds ^ m_sh[w]) : 64'h0);
      m_tc[w] = din_t | (push_t ? ALL1 : 64'h0);
      m_sh[w] = ds;
    end
    cnt_n = m_cnt + int'(push_ok) - int'(pop_ok);
    if (pop_ok) m_rd = (m_rd + 1) % DEPTH;
    m_cnt = cnt_n;
    if (push_t || (pop_t && !empty)) m_ctrl = 1'b1;
    else if (cnt_n == 0 && !push_t && !pop_t && din_t == 64'h0) m_ctrl = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_dout_p"},  dout_p,  exp_dout(1'b0));
    chk({tag, "_dout_c"},  dout_c,  exp_dout(1'b1));
    chk({tag, "_ctrl_p"},  ctrl_p,  m_ctrl);
    chk({tag, "_ctrl_c"},  ctrl_c,  m_ctrl);
    chk({tag, "_full_p"},  full_p,  m_ctrl);
    chk({tag, "_empty_c"}, empty_c, m_ctrl);
    chk({tag, "_sum_p"},   sum_p,   m_sum_p);
    chk({tag, "_sum_c"},   sum_c,   m_sum_c);
  endtask

  // One clock: drive inputs (called at a negedge), step model, check at next negedge.
  task automatic step(input bit p, input bit q, input logic [63:0] d, input bit ptn,
                      input bit qtn, input logic [63:0] dt, input string tag);
    push = p; pop = q; din = d; push_t = ptn; pop_t = qtn; din_t = dt;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle_inputs();
    push = 0; pop = 0; din = '0; push_t = 0; pop_t = 0; din_t = '0;
  endtask

  task automatic do_reset(input string tag);
    idle_inputs();
    arst_n = 1'b0;
    #1;
    model_reset();
    check_all({tag, "_low"});
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    check_all({tag, "_rel"});
    @(negedge clk);
    check_all({tag, "_post"});
  endtask

  initial begin
    logic [3:0] sum_hold;
    idle_inputs();
    arst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("rst");
    arst_n = 1'b1;
    #1;
    check_all("rst_rel");
    @(negedge clk);

    // 1: reset mid-operation clears everything asynchronously
    for (int i = 0; i < 3; i++) step(1, 0, {$urandom, $urandom}, 0, 0, 64'hFF, "t1_push");
    idle_inputs();
    arst_n = 1'b0;
    #1;
    model_reset();
    chk("t1_sum0", sum_p, 4'd0);
    chk("t1_dout0", dout_p, 64'h0);
    chk("t1_ctrl0", ctrl_p, 1'b0);
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    check_all("t1_rel");
    @(negedge clk);

    // 2: clean ordering and registered taint_sum
    step(1, 0, {$urandom, $urandom}, 0, 0, 64'h1,  "t2_push");
    step(1, 0, {$urandom, $urandom}, 0, 0, 64'h0,  "t2_push");
    step(1, 0, {$urandom, $urandom}, 0, 0, 64'hF0, "t2_push");
    step(0, 0, '0, 0, 0, '0, "t2_idle");
    chk("t2_sum_a", sum_p, 4'd2);
    chk("t2_head1", dout_p, 64'h1);
    step(0, 1, '0, 0, 0, '0, "t2_pop");
    chk("t2_head2", dout_p, 64'h0);
    chk("t2_sum_b", sum_p, 4'd2);
    step(0, 1, '0, 0, 0, '0, "t2_pop");
    chk("t2_head3", dout_p, 64'hF0);
    chk("t2_sum_c", sum_p, 4'd1);
    step(0, 1, '0, 0, 0, '0, "t2_pop");
    step(0, 0, '0, 0, 0, '0, "t2_idle");
    chk("t2_sum_d", sum_p, 4'd0);

    // 3: wrap-around, head always the newest entry
    for (int i = 1; i <= 12; i++) begin
      step(1, 0, {$urandom, $urandom}, 0, 0, 64'(i), "t3_push");
      chk("t3_head", dout_p, 64'(i));
      step(0, 1, '0, 0, 0, '0, "t3_pop");
    end

    // 4: full boundary, dropped push, push&pop while full
    for (int i = 0; i < 8; i++)
      step(1, 0, {$urandom, $urandom}, 0, 0, (i % 3 == 0) ? 64'h0 : 64'(i << 4), "t4_fill");
    step(0, 0, '0, 0, 0, '0, "t4_idle");
    sum_hold = sum_p;
    step(1, 0, {$urandom, $urandom}, 0, 0, 64'h0, "t4_drop");
    step(0, 0, '0, 0, 0, '0, "t4_idle");
    chk("t4_sum_kept", sum_p, 4'(sum_hold));
    step(1, 1, {$urandom, $urandom}, 0, 0, 64'hBEEF, "t4_pp");
    for (int i = 0; i < 7; i++) step(0, 1, '0, 0, 0, '0, "t4_drain");
    chk("t4_last", dout_p, 64'hBEEF);
    step(0, 1, '0, 0, 0, '0, "t4_drain");

    // 5: precise vs conservative tainted push into slot 0 (shadow A5, next slot 5A)
    do_reset("t5_rst");
    step(1, 0, 64'hA5, 0, 0, '0, "t5_seed");
    step(0, 1, '0, 0, 0, '0, "t5_seed");
    for (int i = 0; i < 7; i++) step(1, 0, 64'h5A, 0, 0, '0, "t5_fill");
    for (int i = 0; i < 7; i++) step(0, 1, '0, 0, 0, '0, "t5_empty");
    step(1, 0, 64'h5A, 1, 0, '0, "t5_tpush");
    chk("t5_dout_p", dout_p, 64'hFF);
    chk("t5_dout_c", dout_c, ALL1);
    chk("t5_mem_p", dut_p.mem_taint_q[0], 64'hFF);
    chk("t5_mem_c", dut_c.mem_taint_q[0], ALL1);
    chk("t5_ctrl", ctrl_p, 1'b1);
    chk("t5_full", full_p, 1'b1);
    chk("t5_empty", empty_p, 1'b1);

    // 6: ctrl_taint clears when count hits 0, unless a tainted pop lands on that edge
    step(0, 1, '0, 0, 0, '0, "t6_pop");
    chk("t6_clr", ctrl_p, 1'b0);
    step(1, 0, 64'h5A, 1, 0, '0, "t6_tpush");
    step(0, 1, '0, 0, 1, '0, "t6_tpop");
    chk("t6_kept", ctrl_p, 1'b1);
    step(0, 0, '0, 0, 0, '0, "t6_idle");
    chk("t6_clr2", ctrl_p, 1'b0);

    // Sanitised push of unknown data
    step(1, 0, 'x, 1, 0, '0, "xdin");
    step(0, 1, '0, 0, 0, '0, "xdin_pop");

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5,
           ($urandom_range(0, 3) == 0) ? 64'({$urandom_range(0, 3)}) : {$urandom, $urandom},
           $urandom_range(0, 19) < 3, $urandom_range(0, 19) < 3,
           ($urandom_range(0, 1) == 0) ? 64'h0 : {$urandom, $urandom}, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
